mode_controller_gen: RTL and testbench
======================================

MODE_CONTROLLER_GEN -- requirements
Module: mode_controller_gen

Interface
REQ-001 SHALL have parameter N_MODES, default 6: number of display modes.
REQ-002 SHALL have parameter N_FIELDS, default 3: setting fields per settable mode (hour/min/sec).
REQ-003 SHALL have parameter SETTABLE_MASK [N_MODES], default 6'b010101: modes with a setting sub-state.
REQ-004 SHALL have parameter DUAL_MASK [N_MODES], default 6'b011000: modes where the potentiometer selects the button function.
REQ-005 SHALL have parameters POT_W, default 10, and POT_THRESH, default 512: operate-function threshold.
REQ-006 SHALL have parameters DEBOUNCE_CYC, default 500000, LONG_CYC, default 50000000, and SET_TIMEOUT, default 500000000, all in clock cycles.
REQ-007 Clock_50MHz  in  1  sole clock, rising edge.
REQ-008 RESET  in  1  reset; synchronous, active-high.
REQ-009 B_Trigger  in  1  raw button, asynchronous, high = pressed.
REQ-010 PotentiometerValue  in  POT_W  mode-function selector.
REQ-011 Alert_Req  in  1  level; alarm/timer expiry pending.
REQ-012 Mode_Onehot  out  N_MODES  one-hot current mode.
REQ-013 SevenSegMUX_CTRLR  out  clog2(N_MODES+1)  current mode index + 1.
REQ-014 Setting_Active  out  1  high in SETTING.
REQ-015 Field_Index  out  max(1,clog2(N_FIELDS))  field being edited.
REQ-016 Setting_Begin, Setting_Commit, Setting_Abort, Op_Toggle, Op_Clear, Alert_Ack  out  1 each  single-cycle pulses.
REQ-017 Field_Done  out  N_FIELDS  single-cycle pulse on the field just confirmed.

Function
REQ-018 SHALL synchronise B_Trigger through 2 flops, then debounce: level accepted only after DEBOUNCE_CYC consecutive stable cycles.
REQ-019 SHALL emit internal long event exactly once when debounced press duration reaches LONG_CYC; release after a long event SHALL emit nothing.
REQ-020 SHALL emit internal short event on debounced release when press duration < LONG_CYC.
REQ-021 Press counter SHALL saturate at LONG_CYC; no wrap.
REQ-022 All outputs SHALL be registered; pulse outputs SHALL assert the cycle after the internal event and for exactly one cycle.
REQ-023 FSM states: OBSERVE, SETTING; m = mode index, dual = DUAL_MASK[m] and PotentiometerValue >= POT_THRESH, sampled on the event cycle.
REQ-024 OBSERVE, short: Alert_Req high -> Alert_Ack, no mode change; else dual -> Op_Toggle; else m advances, N_MODES-1 wraps to 0.
REQ-025 OBSERVE, long: SETTABLE_MASK[m] and (not DUAL_MASK[m] or dual) -> SETTING, Field_Index=0, Setting_Begin; else dual -> Op_Clear; else ignored.
REQ-026 SETTING, short: Field_Done[Field_Index] pulses; Field_Index = N_FIELDS-1 -> OBSERVE plus Setting_Commit; else Field_Index+1.
REQ-027 SETTING, long: -> OBSERVE, Setting_Abort, no Field_Done.
REQ-028 SETTING with no event for SET_TIMEOUT cycles -> OBSERVE, Setting_Abort; idle counter SHALL clear on every event and on entry.
REQ-029 Mode SHALL never change while in SETTING; Alert_Req SHALL be ignored in SETTING.
REQ-030 Field_Index SHALL be 0 whenever in OBSERVE.
REQ-031 Mode_Onehot SHALL always have exactly one bit set.

Reset
REQ-032 RESET SHALL set mode 0, OBSERVE, Field_Index 0, all pulses 0, all counters 0, SevenSegMUX_CTRLR = 1.
REQ-033 After RESET the classifier SHALL require a debounced released level before counting a press; a button held through reset SHALL generate no event.
REQ-034 RESET mid-setting SHALL abort silently: no Setting_Abort or Setting_Commit pulse.

Structure
REQ-035 A shared package SHALL hold the FSM state enum and the default SETTABLE_MASK, DUAL_MASK and POT_THRESH constants.
REQ-036 Sub-module button_press_classifier SHALL implement REQ-018..021 and output short/long pulses.

Verification (DEBOUNCE_CYC=4, LONG_CYC=16, SET_TIMEOUT=100)
REQ-037 Six short presses from reset -> SevenSegMUX_CTRLR steps 2,3,4,5,6,1.
REQ-038 Mode 0, long press then 3 shorts -> Setting_Begin, Field_Done 001,010,100, Setting_Commit; Field_Index returns 0.
REQ-039 Mode 3, pot=800: short -> Op_Toggle; long -> Op_Clear; pot=100: short -> mode 4.
REQ-040 Mode 2 in SETTING, field 1, idle 100 cycles -> Setting_Abort, mode still 2, Field_Index 0.
REQ-041 Alert_Req=1, mode 1, short press -> Alert_Ack only, mode unchanged; a 2-cycle glitch on B_Trigger -> no event.
REQ-042 RESET asserted with the button held and during SETTING -> mode 0, no pulses, no event until release followed by a new press.

Source files
------------

// File: rtl/mode_controller_gen_pkg.sv
// Shared types and default masks for the display mode controller.
// Mode bit i of each mask corresponds to mode index i.
package mode_controller_gen_pkg;

    typedef enum logic {
        ST_OBSERVE = 1'b0,
        ST_SETTING = 1'b1
    } state_t;

    localparam logic [5:0] DEF_SETTABLE_MASK = 6'b010101;
    localparam logic [5:0] DEF_DUAL_MASK     = 6'b011000;
    localparam int         DEF_POT_THRESH    = 512;

endpackage

// File: rtl/mode_controller_gen_button_press_classifier.sv
// Synchronises and debounces a raw push button, then classifies each press
// as a single-cycle short (released early) or long (held LONG_CYC) pulse.
module button_press_classifier
    import mode_controller_gen_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 500000,
    parameter int LONG_CYC     = 50000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic short_pulse,
    output logic long_pulse
);

    localparam int DW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC + 1) : 1;
    localparam int PW = $clog2(LONG_CYC + 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYC - 1);
    localparam logic [PW-1:0] LONG_FULL = PW'(LONG_CYC);
    localparam logic [PW-1:0] LONG_LAST = PW'(LONG_CYC - 1);

    logic          btn_p0;
    logic          btn_p1;
    logic          db_level;
    logic [DW-1:0] db_cnt;
    logic          armed;
    logic [PW-1:0] press_cnt;

    // Reset treats the button as pressed and disarmed, so a press held
    // through reset is swallowed until a clean debounced release is seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_p0      <= 1'b1;
            btn_p1      <= 1'b1;
            db_level    <= 1'b1;
            db_cnt      <= '0;
            armed       <= 1'b0;
            press_cnt   <= '0;
            short_pulse <= 1'b0;
            long_pulse  <= 1'b0;
        end else begin
            short_pulse <= 1'b0;
            long_pulse  <= 1'b0;
            btn_p0      <= btn;
            btn_p1      <= btn_p0;

            if (btn_p1 == db_level) begin
                db_cnt <= '0;
            end else if (db_cnt == DEB_LAST) begin
                db_level <= btn_p1;
                db_cnt   <= '0;
            end else begin
                db_cnt <= db_cnt + DW'(1);
            end

            // Counter saturates at LONG_CYC, which also marks "long already sent".
            if (db_level) begin
                if (armed && (press_cnt != LONG_FULL)) begin
                    press_cnt <= press_cnt + PW'(1);
                    if (press_cnt == LONG_LAST) begin
                        long_pulse <= 1'b1;
                    end
                end
            end else begin
                armed     <= 1'b1;
                press_cnt <= '0;
                if ((press_cnt != '0) && (press_cnt != LONG_FULL)) begin
                    short_pulse <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mode_controller_gen.sv
// Display mode controller: one button cycles modes, enters per-field setting,
// or (in dual modes, pot above threshold) toggles/clears the mode function.
module mode_controller_gen
    import mode_controller_gen_pkg::*;
#(
    parameter int                  N_MODES       = 6,
    parameter int                  N_FIELDS      = 3,
    parameter logic [N_MODES-1:0]  SETTABLE_MASK = N_MODES'(DEF_SETTABLE_MASK),
    parameter logic [N_MODES-1:0]  DUAL_MASK     = N_MODES'(DEF_DUAL_MASK),
    parameter int                  POT_W         = 10,
    parameter int                  POT_THRESH    = DEF_POT_THRESH,
    parameter int                  DEBOUNCE_CYC  = 500000,
    parameter int                  LONG_CYC      = 50000000,
    parameter int                  SET_TIMEOUT   = 500000000
) (
    input  logic                                         Clock_50MHz,
    input  logic                                         RESET,
    input  logic                                         B_Trigger,
    input  logic [POT_W-1:0]                             PotentiometerValue,
    input  logic                                         Alert_Req,
    output logic [N_MODES-1:0]                           Mode_Onehot,
    output logic [$clog2(N_MODES+1)-1:0]                 SevenSegMUX_CTRLR,
    output logic                                         Setting_Active,
    output logic [((N_FIELDS > 1) ? $clog2(N_FIELDS) : 1)-1:0] Field_Index,
    output logic                                         Setting_Begin,
    output logic                                         Setting_Commit,
    output logic                                         Setting_Abort,
    output logic                                         Op_Toggle,
    output logic                                         Op_Clear,
    output logic                                         Alert_Ack,
    output logic [N_FIELDS-1:0]                          Field_Done
);

    localparam int MW = (N_MODES > 1) ? $clog2(N_MODES) : 1;
    localparam int SW = $clog2(N_MODES + 1);
    localparam int FW = (N_FIELDS > 1) ? $clog2(N_FIELDS) : 1;
    localparam int IW = $clog2(SET_TIMEOUT + 1);
    localparam logic [MW-1:0] LAST_MODE  = MW'(N_MODES - 1);
    localparam logic [FW-1:0] LAST_FIELD = FW'(N_FIELDS - 1);
    localparam logic [IW-1:0] IDLE_LAST  = IW'(SET_TIMEOUT - 1);

    function automatic logic [N_MODES-1:0] mode_onehot(input logic [MW-1:0] idx);
        return N_MODES'(1) << idx;
    endfunction

    logic          short_ev;
    logic          long_ev;
    state_t        state;
    logic [MW-1:0] mode;
    logic [MW-1:0] next_mode;
    logic [IW-1:0] idle_cnt;
    logic          dual_sel;
    logic          go_setting;

    button_press_classifier #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .LONG_CYC     (LONG_CYC)
    ) u_classifier (
        .clk         (Clock_50MHz),
        .rst         (RESET),
        .btn         (B_Trigger),
        .short_pulse (short_ev),
        .long_pulse  (long_ev)
    );

    always_comb begin
        next_mode  = (mode == LAST_MODE) ? '0 : mode + MW'(1);
        dual_sel   = DUAL_MASK[mode] && (PotentiometerValue >= POT_W'(POT_THRESH));
        go_setting = SETTABLE_MASK[mode] && (!DUAL_MASK[mode] || dual_sel);
    end

    always_ff @(posedge Clock_50MHz) begin
        if (RESET) begin
            state             <= ST_OBSERVE;
            mode              <= '0;
            Mode_Onehot       <= mode_onehot('0);
            SevenSegMUX_CTRLR <= SW'(1);
            Setting_Active    <= 1'b0;
            Field_Index       <= '0;
            idle_cnt          <= '0;
            Setting_Begin     <= 1'b0;
            Setting_Commit    <= 1'b0;
            Setting_Abort     <= 1'b0;
            Op_Toggle         <= 1'b0;
            Op_Clear          <= 1'b0;
            Alert_Ack         <= 1'b0;
            Field_Done        <= '0;
        end else begin
            Setting_Begin  <= 1'b0;
            Setting_Commit <= 1'b0;
            Setting_Abort  <= 1'b0;
            Op_Toggle      <= 1'b0;
            Op_Clear       <= 1'b0;
            Alert_Ack      <= 1'b0;
            Field_Done     <= '0;

            case (state)
                ST_OBSERVE: begin
                    if (short_ev) begin
                        if (Alert_Req) begin
                            Alert_Ack <= 1'b1;
                        end else if (dual_sel) begin
                            Op_Toggle <= 1'b1;
                        end else begin
                            mode              <= next_mode;
                            Mode_Onehot       <= mode_onehot(next_mode);
                            SevenSegMUX_CTRLR <= SW'(next_mode) + SW'(1);
                        end
                    end else if (long_ev) begin
                        if (go_setting) begin
                            state          <= ST_SETTING;
                            Setting_Active <= 1'b1;
                            Field_Index    <= '0;
                            idle_cnt       <= '0;
                            Setting_Begin  <= 1'b1;
                        end else if (dual_sel) begin
                            Op_Clear <= 1'b1;
                        end
                    end
                end

                ST_SETTING: begin
                    // Alerts and mode changes are deliberately ignored here.
                    if (short_ev) begin
                        idle_cnt   <= '0;
                        Field_Done <= N_FIELDS'(1) << Field_Index;
                        if (Field_Index == LAST_FIELD) begin
                            state          <= ST_OBSERVE;
                            Setting_Active <= 1'b0;
                            Field_Index    <= '0;
                            Setting_Commit <= 1'b1;
                        end else begin
                            Field_Index <= Field_Index + FW'(1);
                        end
                    end else if (long_ev || (idle_cnt == IDLE_LAST)) begin
                        state          <= ST_OBSERVE;
                        Setting_Active <= 1'b0;
                        Field_Index    <= '0;
                        idle_cnt       <= '0;
                        Setting_Abort  <= 1'b1;
                    end else begin
                        idle_cnt <= idle_cnt + IW'(1);
                    end
                end

                default: begin
                    state          <= ST_OBSERVE;
                    Setting_Active <= 1'b0;
                    Field_Index    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mode_controller_gen.sv
// Directed bench for mode_controller_gen with short debounce/long/timeout values.
module tb_mode_controller_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn;
    logic       alert;
    logic [9:0] pot;
    logic [5:0] onehot;
    logic [2:0] seg;
    logic       sa;
    logic [1:0] fi;
    logic       sb, sc, sab, ot, oc, aa;
    logic [2:0] fd;

    always #5 clk = ~clk;

    mode_controller_gen #(
        .DEBOUNCE_CYC (4),
        .LONG_CYC     (16),
        .SET_TIMEOUT  (100)
    ) dut (
        .Clock_50MHz        (clk),
        .RESET              (rst),
        .B_Trigger          (btn),
        .PotentiometerValue (pot),
        .Alert_Req          (alert),
        .Mode_Onehot        (onehot),
        .SevenSegMUX_CTRLR  (seg),
        .Setting_Active     (sa),
        .Field_Index        (fi),
        .Setting_Begin      (sb),
        .Setting_Commit     (sc),
        .Setting_Abort      (sab),
        .Op_Toggle          (ot),
        .Op_Clear           (oc),
        .Alert_Ack          (aa),
        .Field_Done         (fd)
    );

    int checks = 0;
    int failures = 0;

    // Pulse monitor: counts every high cycle, so a stuck pulse inflates the count.
    int cyc = 0;
    int n_begin = 0, n_commit = 0, n_abort = 0, n_toggle = 0, n_clear = 0, n_ack = 0, n_fd = 0;
    int fd_cyc = 0, abort_cyc = 0;
    logic [2:0] fd_log [0:31];

    always @(negedge clk) begin
        cyc++;
        if (sb)  n_begin++;
        if (sc)  n_commit++;
        if (sab) begin n_abort++; abort_cyc = cyc; end
        if (ot)  n_toggle++;
        if (oc)  n_clear++;
        if (aa)  n_ack++;
        if (fd != 3'b000) begin
            fd_log[n_fd % 32] = fd;
            n_fd++;
            fd_cyc = cyc;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic press(input int hold);
        @(posedge clk); #1 btn = 1'b1;
        repeat (hold) @(posedge clk);
        #1 btn = 1'b0;
        repeat (14) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic short_press();
        press(8);
    endtask

    task automatic long_press();
        press(30);
    endtask

    task automatic test_reset();
        rst = 1'b1; btn = 1'b0; alert = 1'b0; pot = 10'd0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (onehot !== 6'b000001) begin failures++; $display("FAIL reset_onehot got=%b exp=000001", onehot); end
        checks++; if (seg !== 3'd1) begin failures++; $display("FAIL reset_seg got=%0d exp=1", seg); end
        checks++; if (sa !== 1'b0 || fi !== 2'd0) begin failures++; $display("FAIL reset_setting sa=%b fi=%0d exp sa=0 fi=0", sa, fi); end
        checks++; if ({sb, sc, sab, ot, oc, aa, fd} !== 9'd0) begin failures++; $display("FAIL reset_pulses got=%b exp=0", {sb, sc, sab, ot, oc, aa, fd}); end
        repeat (10) @(posedge clk);
    endtask

    task automatic test_mode_cycle();
        logic [2:0] exp_seg;
        logic [5:0] exp_oh;
        for (int i = 0; i < 6; i++) begin
            short_press();
            exp_seg = 3'((i + 1) % 6 + 1);
            exp_oh  = 6'(1) << ((i + 1) % 6);
            checks++; if (seg !== exp_seg) begin failures++; $display("FAIL cycle_seg step=%0d got=%0d exp=%0d", i, seg, exp_seg); end
            checks++; if (onehot !== exp_oh) begin failures++; $display("FAIL cycle_onehot step=%0d got=%b exp=%b", i, onehot, exp_oh); end
        end
    endtask

    task automatic test_setting();
        int b0, c0, f0;
        b0 = n_begin; c0 = n_commit; f0 = n_fd;
        long_press();
        checks++; if (n_begin != b0 + 1) begin failures++; $display("FAIL set_begin got=%0d exp=%0d", n_begin - b0, 1); end
        checks++; if (sa !== 1'b1 || fi !== 2'd0) begin failures++; $display("FAIL set_enter sa=%b fi=%0d exp sa=1 fi=0", sa, fi); end
        short_press();
        checks++; if (fi !== 2'd1) begin failures++; $display("FAIL set_field1 got=%0d exp=1", fi); end
        short_press();
        checks++; if (fi !== 2'd2) begin failures++; $display("FAIL set_field2 got=%0d exp=2", fi); end
        short_press();
        checks++; if (n_fd != f0 + 3) begin failures++; $display("FAIL set_fd_count got=%0d exp=3", n_fd - f0); end
        checks++; if (fd_log[f0 % 32] !== 3'b001 || fd_log[(f0 + 1) % 32] !== 3'b010 || fd_log[(f0 + 2) % 32] !== 3'b100)
            begin failures++; $display("FAIL set_fd_seq got=%b,%b,%b exp=001,010,100", fd_log[f0 % 32], fd_log[(f0 + 1) % 32], fd_log[(f0 + 2) % 32]); end
        checks++; if (n_commit != c0 + 1) begin failures++; $display("FAIL set_commit got=%0d exp=1", n_commit - c0); end
        checks++; if (sa !== 1'b0 || fi !== 2'd0 || seg !== 3'd1) begin failures++; $display("FAIL set_exit sa=%b fi=%0d seg=%0d exp 0,0,1", sa, fi, seg); end
    endtask

    task automatic test_dual();
        int t0, k0;
        short_press(); short_press(); short_press();
        checks++; if (seg !== 3'd4) begin failures++; $display("FAIL dual_reach seg=%0d exp=4", seg); end
        pot = 10'd800;
        t0 = n_toggle; k0 = n_clear;
        short_press();
        checks++; if (n_toggle != t0 + 1 || seg !== 3'd4) begin failures++; $display("FAIL dual_toggle cnt=%0d seg=%0d exp 1,4", n_toggle - t0, seg); end
        long_press();
        checks++; if (n_clear != k0 + 1 || sa !== 1'b0) begin failures++; $display("FAIL dual_clear cnt=%0d sa=%b exp 1,0", n_clear - k0, sa); end
        pot = 10'd100;
        short_press();
        checks++; if (seg !== 3'd5 || n_toggle != t0 + 1) begin failures++; $display("FAIL dual_low seg=%0d toggles=%0d exp 5,1", seg, n_toggle - t0); end
    endtask

    task automatic test_timeout();
        int a0, c0;
        short_press(); short_press(); short_press(); short_press();
        checks++; if (seg !== 3'd3) begin failures++; $display("FAIL tmo_reach seg=%0d exp=3", seg); end
        long_press();
        short_press();
        checks++; if (sa !== 1'b1 || fi !== 2'd1) begin failures++; $display("FAIL tmo_field sa=%b fi=%0d exp 1,1", sa, fi); end
        a0 = n_abort; c0 = n_commit;
        for (int i = 0; i < 200 && n_abort == a0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (n_abort != a0 + 1) begin failures++; $display("FAIL tmo_abort got=%0d exp=1", n_abort - a0); end
        checks++; if ((abort_cyc - fd_cyc) < 99 || (abort_cyc - fd_cyc) > 101) begin failures++; $display("FAIL tmo_delay got=%0d exp=100", abort_cyc - fd_cyc); end
        checks++; if (seg !== 3'd3 || fi !== 2'd0 || sa !== 1'b0 || n_commit != c0) begin failures++; $display("FAIL tmo_state seg=%0d fi=%0d sa=%b commits=%0d exp 3,0,0,0", seg, fi, sa, n_commit - c0); end
    endtask

    task automatic test_alert();
        int a0, t0, f0;
        short_press(); short_press(); short_press(); short_press(); short_press();
        checks++; if (seg !== 3'd2) begin failures++; $display("FAIL alert_reach seg=%0d exp=2", seg); end
        a0 = n_ack; t0 = n_toggle;
        alert = 1'b1;
        short_press();
        alert = 1'b0;
        checks++; if (n_ack != a0 + 1 || seg !== 3'd2 || n_toggle != t0) begin failures++; $display("FAIL alert_ack acks=%0d seg=%0d exp 1,2", n_ack - a0, seg); end
        a0 = n_ack; f0 = n_begin;
        @(posedge clk); #1 btn = 1'b1;
        repeat (2) @(posedge clk);
        #1 btn = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        checks++; if (seg !== 3'd2 || n_ack != a0 || n_begin != f0) begin failures++; $display("FAIL glitch seg=%0d acks=%0d begins=%0d exp 2,0,0", seg, n_ack - a0, n_begin - f0); end
    endtask

    task automatic test_reset_held();
        int b0, c0, a0, f0, t0, k0;
        short_press();
        long_press();
        checks++; if (seg !== 3'd3 || sa !== 1'b1) begin failures++; $display("FAIL rh_setup seg=%0d sa=%b exp 3,1", seg, sa); end
        b0 = n_begin; c0 = n_commit; a0 = n_abort; f0 = n_fd; t0 = n_toggle; k0 = n_clear;
        @(posedge clk); #1 btn = 1'b1; rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (onehot !== 6'b000001 || seg !== 3'd1 || sa !== 1'b0 || fi !== 2'd0) begin failures++; $display("FAIL rh_reset oh=%b seg=%0d sa=%b fi=%0d exp 000001,1,0,0", onehot, seg, sa, fi); end
        checks++; if (n_abort != a0 || n_commit != c0) begin failures++; $display("FAIL rh_silent aborts=%0d commits=%0d exp 0,0", n_abort - a0, n_commit - c0); end
        repeat (40) @(posedge clk);
        #1 btn = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        checks++; if (seg !== 3'd1 || n_begin != b0 || n_fd != f0 || n_toggle != t0 || n_clear != k0 || n_abort != a0)
            begin failures++; $display("FAIL rh_no_event seg=%0d begins=%0d exp seg=1 no events", seg, n_begin - b0); end
        short_press();
        checks++; if (seg !== 3'd2) begin failures++; $display("FAIL rh_new_press seg=%0d exp=2", seg); end
    endtask

    initial begin
        test_reset();
        test_mode_cycle();
        test_setting();
        test_dual();
        test_timeout();
        test_alert();
        test_reset_held();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
